// File: rtl/run_monitor_pkg.sv
// run_monitor_pkg: shared MTC0 code and run-state definitions
package run_monitor_pkg;
    typedef enum logic [1:0] {
        MTC0_NOOP = 2'd0,
        MTC0_PASS = 2'd1,
        MTC0_FAIL = 2'd2,
        MTC0_DONE = 2'd3
    } mtc0_code_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_MEM = 3'd1,
        ST_HOLD     = 3'd2,
        ST_RUN      = 3'd3,
        ST_DONE     = 3'd4,
        ST_FAIL     = 3'd5,
        ST_TIMEOUT  = 3'd6
    } run_state_t;

    function automatic logic is_final(input run_state_t s);
        return s inside {ST_DONE, ST_FAIL, ST_TIMEOUT};
    endfunction
endpackage

// File: rtl/run_monitor_sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    // clear wins over count; count stops at all-ones
    always_comb cnt_d = clr_i ? '0 : (en_i && !(&cnt_q)) ? cnt_q + W'(1) : cnt_q;

    // counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/run_monitor.sv
// run_monitor: sequences a multi-core test run and collects pass/fail and counters
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int N_CORES     = 2,
    parameter int CNT_W       = 32,
    parameter int HOLD_CYCLES = 50,
    parameter int TIMEOUT     = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           mem_ready,
    input  logic [N_CORES-1:0][1:0]        code,
    input  logic [N_CORES-1:0]             retire,
    output logic                           soft_rst_n,
    output logic [2:0]                     state,
    output logic [N_CORES-1:0]             core_done,
    output logic [N_CORES-1:0]             core_fail,
    output logic [CNT_W-1:0]               num_cycles,
    output logic [N_CORES-1:0][CNT_W-1:0]  num_instr,
    output logic                           finished
);
    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    run_state_t         state_q, state_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [N_CORES-1:0] done_q, done_d, fail_q, fail_d;
    logic [N_CORES-1:0] done_set, fail_set, instr_en;
    logic               run, clr, fail_now, to_hit;

    // per-core code decode, sticky status bits and counter controls
    always_comb begin
        done_set = '0;
        fail_set = '0;
        instr_en = '0;
        run      = state_q == ST_RUN;
        clr      = state_q == ST_WAIT_MEM && mem_ready;
        for (int i = 0; i < N_CORES; i++) begin
            done_set[i] = run && code[i] == MTC0_DONE;
            fail_set[i] = run && code[i] == MTC0_FAIL;
            instr_en[i] = run && retire[i] && !done_q[i] && !fail_q[i];
        end
        done_d   = clr ? '0 : done_q | done_set;
        fail_d   = clr ? '0 : fail_q | fail_set;
        fail_now = |(fail_q | fail_set);
        to_hit   = TIMEOUT != 0 && num_cycles == TO_LAST;
    end

    // next-state logic; FAIL beats DONE beats TIMEOUT
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL, ST_TIMEOUT:
                if (start) state_d = ST_WAIT_MEM;
            ST_WAIT_MEM:
                if (mem_ready) begin
                    state_d = HOLD_CYCLES == 0 ? ST_RUN : ST_HOLD;
                    hold_d  = '0;
                end
            ST_HOLD:
                if (hold_q == HOLD_LAST) state_d = ST_RUN;
                else                     hold_d  = hold_q + HW'(1);
            ST_RUN:
                state_d = fail_now ? ST_FAIL : (&done_q) ? ST_DONE : to_hit ? ST_TIMEOUT : ST_RUN;
            default:
                state_d = ST_IDLE;
        endcase
    end

    // state, hold timer and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            done_q  <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_cycles (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr),
        .en_i  (run),
        .cnt_o (num_cycles)
    );

    for (genvar g = 0; g < N_CORES; g++) begin : g_instr
        sat_counter #(.W(CNT_W)) u_instr (
            .clk   (clk),
            .rst_n (rst_n),
            .clr_i (clr),
            .en_i  (instr_en[g]),
            .cnt_o (num_instr[g])
        );
    end

    assign soft_rst_n = state_q inside {ST_RUN, ST_DONE, ST_FAIL};
    assign finished   = is_final(state_q);
    assign state      = state_q;
    assign core_done  = done_q;
    assign core_fail  = fail_q;
endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: table, directed and randomized checks of run_monitor
module tb_run_monitor;
    localparam int S_IDLE = 0, S_WAIT = 1, S_HOLD = 2, S_RUN = 3, S_DONE = 4, S_FAIL = 5, S_TO = 6;
    localparam int TO_A = 1000;
    localparam int RUN_LEN = 1005;

    typedef struct {
        int k0, c0, k1, c1, nret, m;
        int st, cyc, dn, fl, i0, i1;
    } vec_t;

    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;

    logic             a_start = 0, a_mem = 0;
    logic [1:0][1:0]  a_code = '0;
    logic [1:0]       a_ret = '0;
    logic             a_soft, a_fin;
    logic [2:0]       a_state;
    logic [1:0]       a_done, a_fail;
    logic [31:0]      a_cyc;
    logic [1:0][31:0] a_instr;

    logic             b_start = 0, b_mem = 0;
    logic [0:0][1:0]  b_code = '0;
    logic [0:0]       b_ret = '0;
    logic             b_soft, b_fin;
    logic [2:0]       b_state;
    logic [0:0]       b_done, b_fail;
    logic [3:0]       b_cyc;
    logic [0:0][3:0]  b_instr;

    run_monitor #(.N_CORES(2), .CNT_W(32), .HOLD_CYCLES(50), .TIMEOUT(TO_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .mem_ready(a_mem), .code(a_code),
        .retire(a_ret), .soft_rst_n(a_soft), .state(a_state), .core_done(a_done),
        .core_fail(a_fail), .num_cycles(a_cyc), .num_instr(a_instr), .finished(a_fin)
    );

    run_monitor #(.N_CORES(1), .CNT_W(4), .HOLD_CYCLES(0), .TIMEOUT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .mem_ready(b_mem), .code(b_code),
        .retire(b_ret), .soft_rst_n(b_soft), .state(b_state), .core_done(b_done),
        .core_fail(b_fail), .num_cycles(b_cyc), .num_instr(b_instr), .finished(b_fin)
    );

    int n_pass = 0, n_total = 0;
    int kind[2], ecyc[2];
    bit ret_log[2][RUN_LEN+1];
    vec_t tbl[7];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // start a run on dut_a with mem_ready low for m cycles; returns on first RUN cycle
    task automatic start_a(input int m);
        a_mem = (m == 0);
        a_start = 1;
        tick;
        a_start = 0;
        chk("enter WAIT_MEM", a_state, S_WAIT);
        repeat (m) tick;
        if (m > 0) chk("WAIT_MEM holds w/o mem_ready", a_state, S_WAIT);
        a_mem = 1;
        tick;
        chk("enter HOLD", a_state, S_HOLD);
        chk("HOLD clears cycles", a_cyc, 0);
        chk("HOLD clears done|fail", {a_done, a_fail}, 0);
        repeat (49) tick;
        chk("soft_rst_n low in last HOLD", a_soft, 0);
        tick;
        chk("soft_rst_n high in RUN", a_soft, 1);
        chk("enter RUN", a_state, S_RUN);
    endtask

    // drive one whole run: each core gets at most one terminal code at ecyc
    task automatic run_a(input int k0, c0, k1, c1, nret, m, input bit rnd);
        kind[0] = k0; ecyc[0] = c0; kind[1] = k1; ecyc[1] = c1;
        start_a(m);
        for (int k = 1; k <= RUN_LEN; k++) begin
            for (int i = 0; i < 2; i++) begin
                ret_log[i][k] = rnd ? 1'($urandom_range(0, 1)) : (k <= nret);
                a_ret[i] = ret_log[i][k];
                a_code[i] = (kind[i] != 0 && k == ecyc[i]) ? (kind[i] == 1 ? 2'd3 : 2'd2)
                                                            : 2'($urandom_range(0, 1));
            end
            tick;
        end
        a_code = '0;
        a_ret = '0;
    endtask

    task automatic check_a(input string tag, input int st, cyc, dn, fl, i0, i1);
        chk({tag, " state"}, a_state, st);
        chk({tag, " finished"}, a_fin, 1);
        chk({tag, " soft_rst_n"}, a_soft, st != S_TO);
        chk({tag, " num_cycles"}, a_cyc, cyc);
        chk({tag, " core_done"}, a_done, dn);
        chk({tag, " core_fail"}, a_fail, fl);
        chk({tag, " num_instr0"}, a_instr[0], i0);
        chk({tag, " num_instr1"}, a_instr[1], i1);
    endtask

    // run outcome from the schedule: the run ends at the earliest of first fail,
    // the cycle after the last done (all cores done), or the timeout
    task automatic model(output int st, cyc, dn, fl, i0, i1);
        int big, f, d, e;
        bit all_done;
        int cnt[2];
        big = 1 << 30;
        f = big;
        d = 0;
        all_done = 1;
        for (int i = 0; i < 2; i++) begin
            if (kind[i] == 2 && ecyc[i] < f) f = ecyc[i];
            if (kind[i] != 1) all_done = 0;
            else if (ecyc[i] > d) d = ecyc[i];
        end
        d = all_done ? d + 1 : big;
        e = f < d ? f : d;
        if (TO_A < e) e = TO_A;
        st = (f == e) ? S_FAIL : (d == e) ? S_DONE : S_TO;
        cyc = e;
        dn = 0;
        fl = 0;
        for (int i = 0; i < 2; i++) begin
            if (kind[i] == 1 && ecyc[i] <= e) dn |= 1 << i;
            if (kind[i] == 2 && ecyc[i] <= e) fl |= 1 << i;
            cnt[i] = 0;
            for (int k = 1; k <= e; k++)
                if (ret_log[i][k] && (kind[i] == 0 || k <= ecyc[i])) cnt[i]++;
        end
        i0 = cnt[0];
        i1 = cnt[1];
    endtask

    initial begin
        int st, cyc, dn, fl, i0, i1, r;
        tbl[0] = '{1, 100, 1, 250, 10, 0, S_DONE, 251, 3, 0, 10, 10};
        tbl[1] = '{1, 30, 2, 30, 40, 2, S_FAIL, 30, 1, 2, 30, 30};
        tbl[2] = '{0, 0, 0, 0, 0, 1, S_TO, 1000, 0, 0, 0, 0};
        tbl[3] = '{2, 5, 0, 0, 3, 0, S_FAIL, 5, 0, 1, 3, 3};
        tbl[4] = '{1, 999, 1, 998, 5, 0, S_DONE, 1000, 3, 0, 5, 5};
        tbl[5] = '{1, 1000, 1, 10, 20, 0, S_TO, 1000, 3, 0, 20, 10};
        tbl[6] = '{2, 1000, 0, 0, 0, 3, S_FAIL, 1000, 0, 1, 0, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset state", a_state, S_IDLE);
        chk("reset soft_rst_n", a_soft, 0);
        chk("reset finished", a_fin, 0);
        chk("reset num_cycles", a_cyc, 0);
        chk("reset num_instr", a_instr, 0);
        chk("reset done|fail", {a_done, a_fail}, 0);
        rst_n = 1;

        b_mem = 1;
        b_start = 1;
        tick;
        b_start = 0;
        chk("B WAIT_MEM one cycle", b_state, S_WAIT);
        chk("B soft_rst_n low", b_soft, 0);
        tick;
        chk("B no-hold RUN", b_state, S_RUN);
        chk("B soft_rst_n high", b_soft, 1);
        for (int k = 0; k < 20; k++) begin
            b_ret = 1'b1;
            tick;
        end
        b_ret = 1'b0;
        chk("B num_instr saturates", b_instr[0], 15);
        chk("B num_cycles saturates", b_cyc, 15);
        b_code[0] = 2'd3;
        tick;
        b_code[0] = 2'd0;
        chk("B core_done", b_done, 1);
        chk("B still RUN", b_state, S_RUN);
        tick;
        chk("B DONE", b_state, S_DONE);
        chk("B finished", b_fin, 1);
        chk("B num_cycles frozen", b_cyc, 15);

        for (int n = 0; n < 7; n++) begin
            run_a(tbl[n].k0, tbl[n].c0, tbl[n].k1, tbl[n].c1, tbl[n].nret, tbl[n].m, 0);
            check_a($sformatf("vec%0d", n), tbl[n].st, tbl[n].cyc, tbl[n].dn, tbl[n].fl,
                    tbl[n].i0, tbl[n].i1);
        end

        start_a(0);
        for (int k = 1; k <= 20; k++) begin
            a_ret = 2'b11;
            a_code[0] = (k == 5) ? 2'd3 : 2'd0;
            tick;
        end
        a_ret = '0;
        a_code = '0;
        chk("mid core_done", a_done, 1);
        chk("mid num_instr0", a_instr[0], 5);
        chk("mid num_instr1", a_instr[1], 20);
        chk("mid num_cycles", a_cyc, 20);
        a_start = 1;
        tick;
        a_start = 0;
        chk("start ignored in RUN", a_state, S_RUN);
        #2 rst_n = 0;
        #1;
        chk("async reset state", a_state, S_IDLE);
        chk("async reset soft_rst_n", a_soft, 0);
        chk("async reset num_cycles", a_cyc, 0);
        chk("async reset num_instr", a_instr, 0);
        chk("async reset done|fail", {a_done, a_fail}, 0);
        chk("async reset finished", a_fin, 0);
        @(posedge clk);
        #1 rst_n = 1;

        for (int n = 0; n < 8; n++) begin
            kind[0] = 0;
            for (int i = 0; i < 2; i++) begin
                r = $urandom_range(0, 3);
                kind[i] = (r == 3) ? 1 : r;
                ecyc[i] = $urandom_range(1, 600);
            end
            run_a(kind[0], ecyc[0], kind[1], ecyc[1], 0, $urandom_range(0, 4), 1);
            model(st, cyc, dn, fl, i0, i1);
            check_a($sformatf("rand%0d", n), st, cyc, dn, fl, i0, i1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
